// File: rtl/vpu_pkg.sv
// Purpose: shared pathway codes and saturating fixed-point helpers for the VPU.
// Latency: none; combinational functions only.
// Backpressure: none.
// Contents: PATH_* codes, pathway bit positions, fxp_sat / fxp_mul / sat_add.
package vpu_pkg;

  // Pathway codes: [3]=bias [2]=leaky relu [1]=loss [0]=leaky relu derivative
  localparam logic [3:0] PATH_NONE  = 4'b0000;
  localparam logic [3:0] PATH_FWD   = 4'b1100;
  localparam logic [3:0] PATH_TRANS = 4'b1111;
  localparam logic [3:0] PATH_BWD   = 4'b0001;

  localparam int BIT_BIAS = 3;
  localparam int BIT_LR   = 2;
  localparam int BIT_LOSS = 1;
  localparam int BIT_LRD  = 0;

  // Helpers work on a 32-bit container so any DW <= 32 can use them;
  // dw/frac are elaboration constants at every call site.
  localparam int FXP_W = 32;
  typedef logic signed [FXP_W-1:0]   fxp_t;
  typedef logic signed [2*FXP_W-1:0] fxp_wide_t;

  // Clamp to the signed dw-bit range.
  function automatic fxp_t fxp_sat(input fxp_wide_t v, input int dw);
    fxp_wide_t hi;
    fxp_wide_t lo;
    hi = (fxp_wide_t'(1) <<< (dw - 1)) - fxp_wide_t'(1);
    lo = -(fxp_wide_t'(1) <<< (dw - 1));
    if (v > hi)      return fxp_t'(hi);
    else if (v < lo) return fxp_t'(lo);
    else             return fxp_t'(v);
  endfunction

  // Full-width product, arithmetic shift by frac, then saturate.
  function automatic fxp_t fxp_mul(input fxp_t a, input fxp_t b, input int dw, input int frac);
    fxp_wide_t p;
    p = fxp_wide_t'(a) * fxp_wide_t'(b);
    p = p >>> frac;
    return fxp_sat(p, dw);
  endfunction

  function automatic fxp_t sat_add(input fxp_t a, input fxp_t b, input int dw);
    return fxp_sat(fxp_wide_t'(a) + fxp_wide_t'(b), dw);
  endfunction

endpackage

// File: rtl/vpu_lanes_if.sv
// Purpose: bundles the VPU data, valid, side-operand and status buses.
// Latency: none; wiring only.
// Backpressure: none; valid-only buses, the VPU never stalls.
// master drives pathway/data/valid/bias/leak/target/inv_batch; slave returns
// data_out/valid_out/h_count/h_underflow.
interface vpu_lanes_if #(
  parameter int LANES  = 4,
  parameter int DW     = 16,
  parameter int HDEPTH = 32
);
  localparam int CW = $clog2(HDEPTH + 1);

  logic [3:0]          vpu_data_pathway;
  logic [LANES*DW-1:0] vpu_data_in;
  logic [LANES-1:0]    vpu_valid_in;
  logic [LANES*DW-1:0] bias_scalar_in;
  logic [DW-1:0]       lr_leak_factor_in;
  logic [LANES*DW-1:0] loss_target_in;
  logic [DW-1:0]       inv_batch_in;
  logic [LANES*DW-1:0] vpu_data_out;
  logic [LANES-1:0]    vpu_valid_out;
  logic [LANES*CW-1:0] h_count;
  logic [LANES-1:0]    h_underflow;

  modport master (
    output vpu_data_pathway, vpu_data_in, vpu_valid_in, bias_scalar_in,
           lr_leak_factor_in, loss_target_in, inv_batch_in,
    input  vpu_data_out, vpu_valid_out, h_count, h_underflow
  );

  modport slave (
    input  vpu_data_pathway, vpu_data_in, vpu_valid_in, bias_scalar_in,
           lr_leak_factor_in, loss_target_in, inv_batch_in,
    output vpu_data_out, vpu_valid_out, h_count, h_underflow
  );

endinterface

// File: rtl/vpu_lane.sv
// Purpose: one VPU lane: bias -> leaky ReLU -> loss -> ReLU derivative, plus H cache.
// Latency: fixed 4 cycles valid-in to valid-out for every pathway.
// Backpressure: none; accepts one sample per cycle, never stalls.
// Ports: clk/rst, path_in (pathway bits), vld_in/dat_in, bias_in, leak, y_in,
// inv_batch, vld_out/dat_out, h_count (cache occupancy), h_underflow (sticky).
module vpu_lane
  import vpu_pkg::*;
#(
  parameter int DW     = 16,
  parameter int FRAC   = 8,
  parameter int B      = 8,
  parameter int D_OUT  = 4,
  parameter int HDEPTH = 32,
  parameter int CW     = $clog2(HDEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           path_in,
  input  logic                 vld_in,
  input  logic signed [DW-1:0] dat_in,
  input  logic signed [DW-1:0] bias_in,
  input  logic signed [DW-1:0] leak,
  input  logic signed [DW-1:0] y_in,
  input  logic signed [DW-1:0] inv_batch,
  output logic                 vld_out,
  output logic signed [DW-1:0] dat_out,
  output logic [CW-1:0]        h_count,
  output logic                 h_underflow
);

  localparam int RW  = (B > 1) ? $clog2(B) : 1;
  localparam int CLW = (D_OUT > 1) ? $clog2(D_OUT) : 1;
  localparam int PW  = (HDEPTH > 1) ? $clog2(HDEPTH) : 1;

  typedef logic signed [DW-1:0] dat_t;

  function automatic dat_t mul(input dat_t a, input dat_t b);
    return dat_t'(fxp_mul(fxp_t'(a), fxp_t'(b), DW, FRAC));
  endfunction

  function automatic dat_t add_s(input dat_t a, input dat_t b);
    return dat_t'(sat_add(fxp_t'(a), fxp_t'(b), DW));
  endfunction

  function automatic dat_t sub_s(input dat_t a, input dat_t b);
    return dat_t'(sat_add(fxp_t'(a), -fxp_t'(b), DW));
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(HDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Bias column tracking
  logic [3:0]     path_q;
  logic [RW-1:0]  row_ctr;
  logic [CLW-1:0] col_ctr;
  dat_t           b_q;

  // Pipeline registers; each stage carries the pathway bits later stages need
  logic s1_vld, s1_lr, s1_loss, s1_lrd;
  logic s2_vld, s2_lr, s2_loss, s2_lrd;
  logic s3_vld, s3_lrd;
  dat_t s1_dat, s2_dat, s3_g, s3_hd;

  // H cache
  dat_t          cache [HDEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  // Stage combinational results
  dat_t bias_sel, z, h, g, hd, rd_val, d_out;
  logic do_wr, do_rd;

  always_comb begin
    // The first sample of a column uses the live bias; the rest use the latch.
    bias_sel = (row_ctr == '0) ? bias_in : b_q;
    z        = path_in[BIT_BIAS] ? add_s(dat_in, bias_sel) : dat_in;

    h = s1_dat;
    if (s1_lr && !(s1_dat > dat_t'(0))) h = mul(s1_dat, leak);

    do_wr  = s2_vld && s2_loss && s2_lr;
    do_rd  = s2_vld && !s2_loss && s2_lrd;
    rd_val = (h_count == '0) ? dat_t'(0) : cache[rd_ptr];
    g      = s2_loss ? mul(sub_s(s2_dat, y_in), inv_batch) : s2_dat;
    // Backward samples take their activation from the cache, not the pipe.
    hd     = (!s2_loss && s2_lrd) ? rd_val : s2_dat;

    d_out = s3_g;
    if (s3_lrd && !(s3_hd > dat_t'(0))) d_out = mul(s3_g, leak);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      path_q      <= '0;
      row_ctr     <= '0;
      col_ctr     <= '0;
      b_q         <= '0;
      s1_vld      <= 1'b0;
      s1_lr       <= 1'b0;
      s1_loss     <= 1'b0;
      s1_lrd      <= 1'b0;
      s1_dat      <= '0;
      s2_vld      <= 1'b0;
      s2_lr       <= 1'b0;
      s2_loss     <= 1'b0;
      s2_lrd      <= 1'b0;
      s2_dat      <= '0;
      s3_vld      <= 1'b0;
      s3_lrd      <= 1'b0;
      s3_g        <= '0;
      s3_hd       <= '0;
      vld_out     <= 1'b0;
      dat_out     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      h_count     <= '0;
      h_underflow <= 1'b0;
    end else begin
      path_q <= path_in;
      if (vld_in && path_in[BIT_BIAS] && row_ctr == '0) b_q <= bias_in;

      // A pathway change restarts column tracking one cycle later.
      if (path_in != path_q) begin
        row_ctr <= '0;
        col_ctr <= '0;
      end else if (vld_in && path_in[BIT_BIAS]) begin
        if (row_ctr == RW'(B - 1)) begin
          row_ctr <= '0;
          col_ctr <= (col_ctr == CLW'(D_OUT - 1)) ? '0 : col_ctr + 1'b1;
        end else begin
          row_ctr <= row_ctr + 1'b1;
        end
      end

      s1_vld  <= vld_in;
      s1_lr   <= path_in[BIT_LR];
      s1_loss <= path_in[BIT_LOSS];
      s1_lrd  <= path_in[BIT_LRD];
      s1_dat  <= z;

      s2_vld  <= s1_vld;
      s2_lr   <= s1_lr;
      s2_loss <= s1_loss;
      s2_lrd  <= s1_lrd;
      s2_dat  <= h;

      s3_vld <= s2_vld;
      s3_lrd <= s2_lrd;
      s3_g   <= g;
      s3_hd  <= hd;

      vld_out <= s3_vld;
      dat_out <= d_out;

      // Writes and reads are exclusive (bit1 selects one or the other).
      if (do_wr) begin
        wr_ptr <= ptr_inc(wr_ptr);
        // Full: the write lands on the oldest entry, so drop it from the read side.
        if (h_count == CW'(HDEPTH)) rd_ptr <= ptr_inc(rd_ptr);
        else                        h_count <= h_count + 1'b1;
      end else if (do_rd) begin
        if (h_count == '0) begin
          h_underflow <= 1'b1;
        end else begin
          rd_ptr  <= ptr_inc(rd_ptr);
          h_count <= h_count - 1'b1;
        end
      end
    end
  end

  // Cache storage has no reset; occupancy is tracked by h_count.
  always_ff @(posedge clk) begin
    if (do_wr) cache[wr_ptr] <= s2_dat;
  end

endmodule

// File: rtl/vpu_lanes.sv
// Purpose: LANES-wide vector processing unit between systolic array and UB.
// Latency: fixed 4 cycles per lane, independent of pathway.
// Backpressure: none; one sample per lane per cycle, no stalls.
// Ports: clk, rst (async active-high), bus (vpu_lanes_if.slave) carrying all
// data/valid/operand inputs and data/valid/h_count/h_underflow outputs.
module vpu_lanes
  import vpu_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DW     = 16,
  parameter int FRAC   = 8,
  parameter int B      = 8,
  parameter int D_OUT  = 4,
  parameter int HDEPTH = B * D_OUT
) (
  input logic        clk,
  input logic        rst,
  vpu_lanes_if.slave bus
);

  localparam int CW = $clog2(HDEPTH + 1);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [DW-1:0] dout;
    logic                 vout;
    logic [CW-1:0]        hcnt;
    logic                 uflow;

    vpu_lane #(
      .DW(DW), .FRAC(FRAC), .B(B), .D_OUT(D_OUT), .HDEPTH(HDEPTH), .CW(CW)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .path_in     (bus.vpu_data_pathway),
      .vld_in      (bus.vpu_valid_in[i]),
      .dat_in      (bus.vpu_data_in[i*DW +: DW]),
      .bias_in     (bus.bias_scalar_in[i*DW +: DW]),
      .leak        (bus.lr_leak_factor_in),
      .y_in        (bus.loss_target_in[i*DW +: DW]),
      .inv_batch   (bus.inv_batch_in),
      .vld_out     (vout),
      .dat_out     (dout),
      .h_count     (hcnt),
      .h_underflow (uflow)
    );

    assign bus.vpu_data_out[i*DW +: DW] = dout;
    assign bus.vpu_valid_out[i]         = vout;
    assign bus.h_count[i*CW +: CW]      = hcnt;
    assign bus.h_underflow[i]           = uflow;
  end

endmodule

// File: tb/tb_vpu_lanes.sv
// Purpose: directed self-checking bench for vpu_lanes.
// Latency: expects every sample on valid_out exactly 4 cycles after valid_in.
// Backpressure: none; stimulus is driven on falling edges, outputs checked there too.
module tb_vpu_lanes;
  import vpu_pkg::*;

  localparam int LANES = 4, DW = 16, FRAC = 8, B = 8, D_OUT = 4, HDEPTH = 32, CW = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vpu_lanes_if #(.LANES(LANES), .DW(DW), .HDEPTH(HDEPTH)) bus ();

  vpu_lanes #(
    .LANES(LANES), .DW(DW), .FRAC(FRAC), .B(B), .D_OUT(D_OUT), .HDEPTH(HDEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic set_path(input logic [3:0] p);
    @(negedge clk);
    bus.vpu_data_pathway = p;
    @(negedge clk);
  endtask

  // Bounce through PATH_NONE so the bias column counters start from row 0.
  task automatic restart(input logic [3:0] p);
    set_path(PATH_NONE);
    set_path(p);
  endtask

  // One valid cycle on the lanes in mask; ends on the following falling edge.
  task automatic send(input logic [3:0] mask, input logic [15:0] x,
                      input logic [15:0] b, input logic [15:0] y);
    @(negedge clk);
    bus.vpu_valid_in   = mask;
    bus.vpu_data_in    = {4{x}};
    bus.bias_scalar_in = {4{b}};
    bus.loss_target_in = {4{y}};
    @(negedge clk);
    bus.vpu_valid_in = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (bus.vpu_valid_out !== 4'h0) begin miscompares++; $display("FAIL reset_valid: got %h want 0", bus.vpu_valid_out); end
    vectors++; if (bus.vpu_data_out !== 64'h0) begin miscompares++; $display("FAIL reset_data: got %h want 0", bus.vpu_data_out); end
    vectors++; if (bus.h_count !== 24'h0) begin miscompares++; $display("FAIL reset_hcount: got %h want 0", bus.h_count); end
    vectors++; if (bus.h_underflow !== 4'h0) begin miscompares++; $display("FAIL reset_uflow: got %h want 0", bus.h_underflow); end
    rst = 1'b0;
  endtask

  task automatic test_forward();
    bus.lr_leak_factor_in = 16'h0080;
    restart(PATH_FWD);
    send(4'hF, 16'h0200, 16'hFF00, 16'h0000);
    repeat (2) @(negedge clk);
    vectors++; if (bus.vpu_valid_out !== 4'h0) begin miscompares++; $display("FAIL fwd_pos_early: valid %h want 0", bus.vpu_valid_out); end
    @(negedge clk);
    vectors++; if (bus.vpu_valid_out !== 4'hF) begin miscompares++; $display("FAIL fwd_pos_valid: valid %h want f", bus.vpu_valid_out); end
    vectors++; if (bus.vpu_data_out !== {4{16'h0100}}) begin miscompares++; $display("FAIL fwd_pos_data: got %h want %h", bus.vpu_data_out, {4{16'h0100}}); end
    restart(PATH_FWD);
    send(4'hF, 16'hFC00, 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    vectors++; if (bus.vpu_valid_out !== 4'hF) begin miscompares++; $display("FAIL fwd_neg_valid: valid %h want f", bus.vpu_valid_out); end
    vectors++; if (bus.vpu_data_out !== {4{16'hFE00}}) begin miscompares++; $display("FAIL fwd_neg_data: got %h want %h", bus.vpu_data_out, {4{16'hFE00}}); end
  endtask

  task automatic test_saturation();
    restart(4'b1000);
    send(4'hF, 16'h7F00, 16'h0200, 16'h0000);
    repeat (3) @(negedge clk);
    vectors++; if (bus.vpu_data_out !== {4{16'h7FFF}}) begin miscompares++; $display("FAIL sat_pos: got %h want %h", bus.vpu_data_out, {4{16'h7FFF}}); end
    restart(4'b1000);
    send(4'hF, 16'h8000, 16'hFF00, 16'h0000);
    repeat (3) @(negedge clk);
    vectors++; if (bus.vpu_valid_out !== 4'hF) begin miscompares++; $display("FAIL sat_neg_valid: valid %h want f", bus.vpu_valid_out); end
    vectors++; if (bus.vpu_data_out !== {4{16'h8000}}) begin miscompares++; $display("FAIL sat_neg: got %h want %h", bus.vpu_data_out, {4{16'h8000}}); end
  endtask

  // Nine back-to-back lane-0 samples: the 9th starts a new column.
  task automatic test_bias_latch();
    logic [15:0] xk, exp;
    restart(4'b1000);
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (c >= 4) begin
        xk  = 16'(16 * (c - 3));
        exp = xk + ((c - 4 == 8) ? 16'h0200 : 16'h0100);
        vectors++; if (bus.vpu_valid_out !== 4'b0001) begin miscompares++; $display("FAIL bias_valid[%0d]: valid %h want 1", c - 4, bus.vpu_valid_out); end
        vectors++; if (bus.vpu_data_out[15:0] !== exp) begin miscompares++; $display("FAIL bias_data[%0d]: got %h want %h", c - 4, bus.vpu_data_out[15:0], exp); end
      end
      if (c < 9) begin
        bus.vpu_valid_in   = 4'b0001;
        bus.vpu_data_in    = {4{16'(16 * (c + 1))}};
        bus.bias_scalar_in = {4{(c == 0) ? 16'h0100 : 16'h0200}};
      end else begin
        bus.vpu_valid_in = '0;
      end
    end
  endtask

  task automatic test_transition();
    bus.inv_batch_in = 16'h0040;
    restart(PATH_TRANS);
    send(4'hF, 16'h0300, 16'h0000, 16'h0100);
    repeat (3) @(negedge clk);
    vectors++; if (bus.vpu_data_out !== {4{16'h0080}}) begin miscompares++; $display("FAIL trans_pos: got %h want %h", bus.vpu_data_out, {4{16'h0080}}); end
    send(4'hF, 16'hFE00, 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    vectors++; if (bus.vpu_valid_out !== 4'hF) begin miscompares++; $display("FAIL trans_neg_valid: valid %h want f", bus.vpu_valid_out); end
    vectors++; if (bus.vpu_data_out !== {4{16'hFFE0}}) begin miscompares++; $display("FAIL trans_neg: got %h want %h", bus.vpu_data_out, {4{16'hFFE0}}); end
    vectors++; if (bus.h_count !== {4{6'd2}}) begin miscompares++; $display("FAIL trans_hcount: got %h want %h", bus.h_count, {4{6'd2}}); end
  endtask

  task automatic test_backward();
    set_path(PATH_BWD);
    send(4'hF, 16'h0100, 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    vectors++; if (bus.vpu_data_out !== {4{16'h0100}}) begin miscompares++; $display("FAIL bwd_first: got %h want %h", bus.vpu_data_out, {4{16'h0100}}); end
    vectors++; if (bus.h_count !== {4{6'd1}}) begin miscompares++; $display("FAIL bwd_hcount1: got %h want %h", bus.h_count, {4{6'd1}}); end
    send(4'hF, 16'h0100, 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    vectors++; if (bus.vpu_data_out !== {4{16'h0080}}) begin miscompares++; $display("FAIL bwd_second: got %h want %h", bus.vpu_data_out, {4{16'h0080}}); end
    vectors++; if (bus.h_count !== 24'h0) begin miscompares++; $display("FAIL bwd_hcount0: got %h want 0", bus.h_count); end
    vectors++; if (bus.h_underflow !== 4'h0) begin miscompares++; $display("FAIL bwd_no_uflow: got %h want 0", bus.h_underflow); end
    send(4'hF, 16'h0100, 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    vectors++; if (bus.vpu_data_out !== {4{16'h0080}}) begin miscompares++; $display("FAIL bwd_empty_data: got %h want %h", bus.vpu_data_out, {4{16'h0080}}); end
    vectors++; if (bus.h_underflow !== 4'hF) begin miscompares++; $display("FAIL bwd_uflow: got %h want f", bus.h_underflow); end
    vectors++; if (bus.h_count !== 24'h0) begin miscompares++; $display("FAIL bwd_hcount_hold: got %h want 0", bus.h_count); end
  endtask

  task automatic test_reset_midstream();
    set_path(PATH_TRANS);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 4) begin
        vectors++; if (bus.vpu_data_out !== {4{16'h0040}}) begin miscompares++; $display("FAIL mid_data: got %h want %h", bus.vpu_data_out, {4{16'h0040}}); end
        vectors++; if (bus.h_count !== {4{6'd2}}) begin miscompares++; $display("FAIL mid_hcount: got %h want %h", bus.h_count, {4{6'd2}}); end
      end
      bus.vpu_valid_in   = 4'hF;
      bus.vpu_data_in    = {4{16'h0100}};
      bus.bias_scalar_in = '0;
      bus.loss_target_in = '0;
    end
    #1 rst = 1'b1;
    #1;
    vectors++; if (bus.vpu_valid_out !== 4'h0) begin miscompares++; $display("FAIL rst_valid: got %h want 0", bus.vpu_valid_out); end
    vectors++; if (bus.h_count !== 24'h0) begin miscompares++; $display("FAIL rst_hcount: got %h want 0", bus.h_count); end
    vectors++; if (bus.h_underflow !== 4'h0) begin miscompares++; $display("FAIL rst_uflow: got %h want 0", bus.h_underflow); end
    vectors++; if (bus.vpu_data_out !== 64'h0) begin miscompares++; $display("FAIL rst_data: got %h want 0", bus.vpu_data_out); end
    @(negedge clk);
    bus.vpu_valid_in = '0;
    rst = 1'b0;
    send(4'hF, 16'h0200, 16'h0000, 16'h0000);
    repeat (2) @(negedge clk);
    vectors++; if (bus.vpu_valid_out !== 4'h0) begin miscompares++; $display("FAIL post_rst_early: valid %h want 0", bus.vpu_valid_out); end
    @(negedge clk);
    vectors++; if (bus.vpu_valid_out !== 4'hF) begin miscompares++; $display("FAIL post_rst_valid: valid %h want f", bus.vpu_valid_out); end
    vectors++; if (bus.vpu_data_out !== {4{16'h0080}}) begin miscompares++; $display("FAIL post_rst_data: got %h want %h", bus.vpu_data_out, {4{16'h0080}}); end
    vectors++; if (bus.h_count !== {4{6'd1}}) begin miscompares++; $display("FAIL post_rst_hcount: got %h want %h", bus.h_count, {4{6'd1}}); end
  endtask

  initial begin
    rst                   = 1'b1;
    bus.vpu_data_pathway  = PATH_NONE;
    bus.vpu_data_in       = '0;
    bus.vpu_valid_in      = '0;
    bus.bias_scalar_in    = '0;
    bus.lr_leak_factor_in = 16'h0080;
    bus.loss_target_in    = '0;
    bus.inv_batch_in      = 16'h0040;
    test_reset();
    test_forward();
    test_saturation();
    test_bias_latch();
    test_transition();
    test_backward();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vpu_lanes.md
Name: vpu_lanes

Overview:
Parametrised next-generation vector processing unit that sits between the systolic array outputs and the unified buffer (UB). It provides LANES independent lanes with a fixed 4-stage pipeline: bias, leaky ReLU, loss, and leaky-ReLU derivative. Forward, transition and backward pathways are all functional. A per-lane H cache stores activations during the transition pathway and replays them during the backward pass.

Parameters:
LANES, 4, number of lanes (systolic array columns)
DW, 16, signed fixed-point data width
FRAC, 8, fractional bits (Q(DW-FRAC).FRAC)
B, 8, rows (batch elements) per neuron column
D_OUT, 4, neuron columns per pass
HDEPTH, B*D_OUT, H cache entries per lane

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
vpu_data_pathway  in  4  [3]=bias [2]=lr [1]=loss [0]=lr_d
vpu_data_in  in  LANES*DW  systolic array results, lane i at [i*DW +: DW]
vpu_valid_in  in  LANES  per-lane valid
bias_scalar_in  in  LANES*DW  per-lane bias from UB
lr_leak_factor_in  in  DW  leak factor, shared by all lanes
loss_target_in  in  LANES*DW  per-lane target Y from UB
inv_batch_in  in  DW  loss scale (2/B in Q format)
vpu_data_out  out  LANES*DW  results to UB
vpu_valid_out  out  LANES  per-lane output valid
h_count  out  LANES*$clog2(HDEPTH+1)  valid H cache entries per lane
h_underflow  out  LANES  sticky flag: backward read from an empty cache

Behaviour:
- Reset (asynchronous): all outputs 0; all pipeline registers, counters and cache pointers 0; h_underflow cleared. Cache contents are don't-care.
- Latency: always exactly 4 cycles from vpu_valid_in to vpu_valid_out on the same lane, whatever the pathway. A disabled stage registers its input unchanged. No stalls; full throughput of 1 sample per lane per cycle.
- Each sample carries its own pathway bits down the pipeline. A pathway change affects only newly entering samples; in-flight samples finish under their original mode.
- Stage 1, bias: Z = sat(x + b).
  - b is latched per lane on the first valid of each column (row_ctr==0); that same sample uses bias_scalar_in directly.
  - row_ctr counts valids 0..B-1, then wraps and increments col_ctr. col_ctr wraps at D_OUT-1.
  - Counters advance only when bit3 is set and valid is high.
  - Counters return to 0 on the cycle after vpu_data_pathway changes value (a registered copy is compared).
- Stage 2, leaky ReLU: H = Z>0 ? Z : mul(Z, leak).
- Stage 3, loss (bit1): g = mul(sat(H - Y), inv_batch). Y is sampled at stage-3 entry.
  - If bit2 is also set, H is written to the lane cache at wr_ptr.
  - wr_ptr wraps HDEPTH-1 -> 0. h_count saturates at HDEPTH; a write when full overwrites the oldest entry.
  - In backward mode (bit1=0, bit0=1), the cache is read at rd_ptr, rd_ptr advances, and h_count decrements.
  - A backward read with h_count==0 sets h_underflow and supplies H=0.
- Stage 4, derivative (bit0): out = Hd>0 ? g : mul(g, leak).
  - Hd is the stage-3 H in transition mode, or the cache read in backward mode.
  - In backward mode the incoming data is treated as g.
- Arithmetic:
  - mul takes the full 2*DW product, shifts it arithmetically right by FRAC, and saturates to the DW signed range.
  - sat clamps to [-2^(DW-1), 2^(DW-1)-1].
- Legal codes: 0000, 1100, 1111, 0001. Other codes execute the same per-bit rules above.
- Lanes are fully independent.

Decomposition:
- vpu_pkg holds:
  - pathway localparams: PATH_NONE, PATH_FWD, PATH_TRANS, PATH_BWD
  - functions fxp_mul and sat_add, parametrised via DW/FRAC
- Sub-module vpu_lane holds one lane's pipeline, bias counters and H cache. vpu_lanes instantiates LANES copies in a generate loop and handles port slicing only.

Test Plan:
1. Forward 1100, DW16 FRAC8, leak 0x0080: x=0x0200 with b=0xFF00 -> out 0x0100 after 4 cycles; x=0xFC00 with b=0 -> 0xFE00.
2. Saturation: x=0x7F00, b=0x0200, pathway 1000 -> 0x7FFF; x=0x8000, b=0xFF00 -> 0x8000.
3. Bias latch: lane0 gets 9 valids with bias_scalar changing after the first -> samples 1-8 use the first bias, sample 9 uses the current bias.
4. Transition 1111, inv_batch 0x0040:
   - x=0x0300, Y=0x0100 -> out 0x0080.
   - x=0xFE00, Y=0 -> H=0xFF00, out 0xFFE0.
   - h_count=2 afterwards.
5. Backward 0001 following test 4: inputs 0x0100, 0x0100 -> outputs 0x0100, 0x0080, h_count=0. A third input sets h_underflow=1 and outputs 0x0080.
6. Assert rst mid-stream with valids in flight -> vpu_valid_out=0 and h_count=0 immediately; after release, the first new sample emerges at exactly 4 cycles.
